// File: rtl/uart_hex_encoder_if.sv
// Word-in / UART-byte-out bundle shared by the hex encoder and whatever surrounds it.
// Latency: none, pure wiring.
// Backpressure: words use valid/ready; bytes wait on the transmitter's active/done flags.
interface uart_hex_encoder_if #(
    parameter int NIBBLES = 4
);
    logic                   i_word_valid;
    logic [4*NIBBLES-1:0]   i_word;
    logic                   o_word_ready;
    logic                   o_tx_start;
    logic [7:0]             o_tx_byte;
    logic                   i_tx_active;
    logic                   i_tx_done;
    logic                   o_busy;
    logic                   o_frame_done;

    // Environment side: word producer plus UART transmitter.
    modport master (
        output i_word_valid, i_word, i_tx_active, i_tx_done,
        input  o_word_ready, o_tx_start, o_tx_byte, o_busy, o_frame_done
    );

    // Encoder side.
    modport slave (
        input  i_word_valid, i_word, i_tx_active, i_tx_done,
        output o_word_ready, o_tx_start, o_tx_byte, o_busy, o_frame_done
    );
endinterface

// File: rtl/uart_hex_encoder.sv
// Encodes a NIBBLES-digit word as ASCII hex (MS nibble first), optional CR/LF via UART_HEX_CRLF_EN.
// Latency: first byte request one cycle after accept; one byte per transmitter active/done round trip.
// Backpressure: ready only in IDLE; stalls indefinitely in SEND until the transmitter reports active.
module uart_hex_encoder #(
    parameter int NIBBLES   = 4,
    parameter int LOWERCASE = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    uart_hex_encoder_if.slave bus
);
    localparam int W = 4 * NIBBLES;
`ifdef UART_HEX_CRLF_EN
    localparam int NCHARS = NIBBLES + 2;
`else
    localparam int NCHARS = NIBBLES;
`endif
    // Counter can hold NIBBLES+2 so it never wraps even in the CR/LF build.
    localparam int CW = $clog2(NIBBLES + 3);
    localparam logic [CW-1:0] LAST_IDX = CW'(NCHARS - 1);
`ifdef UART_HEX_CRLF_EN
    localparam logic [CW-1:0] DIGITS = CW'(NIBBLES);
`endif

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    word_q;
    logic [CW-1:0]   cnt_q;
    logic            word_ready_q;
    logic            tx_start_q;
    logic [7:0]      tx_byte_q;
    logic            busy_q;
    logic            frame_done_q;

    logic            accept;
    logic [CW-1:0]   cnt_d;
    logic [W-1:0]    word_d;
    logic [7:0]      next_byte_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        logic [7:0] alpha;
        alpha = (LOWERCASE != 0) ? 8'h61 : 8'h41;
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return alpha + {4'h0, n} - 8'd10;
    endfunction

    assign accept = bus.i_word_valid & word_ready_q;
    assign cnt_d  = cnt_q + CW'(1);
    // The latched word is shifted so the next digit is always the top nibble.
    assign word_d = word_q << 4;

    // Character that follows the one currently in flight.
    always_comb begin
        next_byte_d = hex_ascii(word_d[W-1 -: 4]);
`ifdef UART_HEX_CRLF_EN
        if (cnt_d == DIGITS) begin
            next_byte_d = 8'h0D;
        end else if (cnt_d > DIGITS) begin
            next_byte_d = 8'h0A;
        end
`endif
    end

    // Frame sequencer; every output comes straight from a register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            word_q       <= '0;
            cnt_q        <= '0;
            word_ready_q <= 1'b1;
            tx_start_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        word_q       <= bus.i_word;
                        cnt_q        <= '0;
                        tx_byte_q    <= hex_ascii(bus.i_word[W-1 -: 4]);
                        tx_start_q   <= 1'b1;
                        word_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= SEND;
                    end
                end
                SEND: begin
                    // Transmitter owns the byte once it reports active.
                    if (bus.i_tx_active) begin
                        tx_start_q <= 1'b0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    // Leaving WAIT on the first done cycle means a stretched done counts once.
                    if (bus.i_tx_done && !bus.i_tx_active) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == LAST_IDX) begin
                            frame_done_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            word_q     <= word_d;
                            tx_byte_q  <= next_byte_d;
                            tx_start_q <= 1'b1;
                            state_q    <= SEND;
                        end
                    end
                end
                DONE: begin
                    word_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_word_ready = word_ready_q;
    assign bus.o_tx_start   = tx_start_q;
    assign bus.o_tx_byte    = tx_byte_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_frame_done = frame_done_q;
endmodule

// File: doc/uart_hex_encoder.md
UART_HEX_ENCODER -- requirements
Module: uart_hex_encoder

Interface
REQ-001 Parameter NIBBLES, default 4: number of hex digits per word (1..8).
REQ-002 Parameter LOWERCASE, default 0: 0 emits 'A'-'F' (0x41-0x46); 1 emits 'a'-'f' (0x61-0x66).
REQ-003 Port i_clk, input, 1: sole clock; all state on rising edge.
REQ-004 Port i_rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port i_word_valid, input, 1: word offered for encoding.
REQ-006 Port i_word, input, 4*NIBBLES: word to encode, sampled on the accept cycle.
REQ-007 Port o_word_ready, output, 1: encoder can accept a word; accept occurs when i_word_valid & o_word_ready.
REQ-008 Port o_tx_start, output, 1: request to the UART transmitter byte port.
REQ-009 Port o_tx_byte, output, 8: ASCII character to transmit; stable while o_tx_start is high.
REQ-010 Port i_tx_active, input, 1: UART transmitter busy flag.
REQ-011 Port i_tx_done, input, 1: UART transmitter completion pulse; may be high for more than one cycle.
REQ-012 Port o_busy, output, 1: high from the cycle after accept until frame end.
REQ-013 Port o_frame_done, output, 1: one-cycle pulse when the last character of a word completes.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, WAIT and DONE, with all outputs registered.
REQ-015 IDLE: o_word_ready=1; on accept, latch i_word, clear the char counter, load o_tx_byte with the first character, and go to SEND.
REQ-016 SEND: hold o_tx_start=1 and o_tx_byte constant until i_tx_active=1 is sampled, then deassert o_tx_start and go to WAIT.
REQ-017 WAIT: on i_tx_done=1 & i_tx_active=0, increment the char counter; if characters remain, load the next o_tx_byte and go to SEND, else go to DONE.
REQ-018 DONE: o_frame_done=1 for exactly one cycle, then go to IDLE; o_word_ready SHALL rise in the cycle after the o_frame_done pulse.
REQ-019 Characters SHALL be emitted most-significant nibble first; nibble n<10 maps to 0x30+n, and n>=10 maps to 0x41+n-10 (or 0x61+n-10 if LOWERCASE=1).
REQ-020 The char counter SHALL be wide enough for NIBBLES+2 and SHALL never wrap within a frame.
REQ-021 i_word_valid outside IDLE SHALL be ignored, and i_word SHALL NOT be resampled.
REQ-022 If i_word_valid is held high continuously, a new word SHALL be accepted in the first IDLE cycle after the previous frame's DONE.
REQ-023 i_tx_done outside WAIT SHALL be ignored; a multi-cycle done SHALL NOT advance the counter twice.
REQ-024 The encoder SHALL NOT time out; a stalled i_tx_active SHALL hold the encoder in SEND indefinitely.

Reset
REQ-025 Asserting i_rst SHALL force IDLE immediately, without waiting for a clock.
REQ-026 Reset values: o_word_ready=1, o_tx_start=0, o_tx_byte=0x00, o_busy=0, o_frame_done=0, counter=0, latched word=0.
REQ-027 Reset mid-frame SHALL drop the remaining characters; a byte already started in the transmitter is not aborted by this block.

Configuration
REQ-028 Macro UART_HEX_CRLF_EN defined: after the hex digits the encoder SHALL send 0x0D then 0x0A, so each frame is NIBBLES+2 characters.
REQ-029 Macro UART_HEX_CRLF_EN undefined: each frame SHALL be exactly NIBBLES characters, and the CR/LF logic SHALL be absent.

Verification
REQ-030 i_word=0x1A2F, defaults, CRLF_EN defined -> bytes 0x31,0x41,0x32,0x46,0x0D,0x0A, then one o_frame_done pulse.
REQ-031 i_word=0xFFFF, LOWERCASE=1, CRLF_EN undefined -> bytes 0x66,0x66,0x66,0x66; o_frame_done after the fourth i_tx_done.
REQ-032 i_word=0x0009, then i_word_valid pulsed with 0xBEEF during byte 2 -> output 0x30,0x30,0x30,0x39 only; 0xBEEF is never sent.
REQ-033 i_word_valid held high with 0x1234 then 0xABCD, model transmitter with 2-cycle done -> two complete frames, in order, no duplicated characters.
REQ-034 i_rst asserted while in WAIT on byte 3 -> o_tx_start=0 and o_word_ready=1 without waiting for a clock edge; the next word encodes correctly from its first digit.
REQ-035 i_tx_active held 0 for 1000 cycles after accept -> o_tx_start stays 1 with o_tx_byte stable; release -> normal frame completion.
